// File: rtl/sf_camera_pixel_packer_pkg.sv
// Shared constants and helpers for the camera pixel packer: widths, FSM states,
// byte order and ping-pong buffer selection.
package sf_camera_pixel_packer_pkg;

    localparam int DATA_W      = 32;
    localparam int BYTE_W      = 8;
    localparam int FIFO_SIZE_W = 24;

    // First byte of a word lands in the most significant lane.
    localparam bit BYTE_ORDER_BIG = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    function automatic logic [1:0] first_ready(input logic [1:0] rdy);
        if (rdy[0])
            return 2'b01;
        else if (rdy[1])
            return 2'b10;
        else
            return 2'b00;
    endfunction

endpackage

// File: rtl/sf_camera_pixel_packer_if.sv
// Write side of the camera ping-pong FIFO: buffer ready/activate handshake,
// active buffer size and the word write strobe.
interface sf_camera_pixel_packer_if;
    import sf_camera_pixel_packer_pkg::*;

    logic [1:0]             wfifo_ready;
    logic [1:0]             wfifo_activate;
    logic [FIFO_SIZE_W-1:0] wfifo_size;
    logic                   wfifo_strobe;
    logic [DATA_W-1:0]      wfifo_data;

    modport master (
        input  wfifo_ready,
        input  wfifo_size,
        output wfifo_activate,
        output wfifo_strobe,
        output wfifo_data
    );

    modport slave (
        output wfifo_ready,
        output wfifo_size,
        input  wfifo_activate,
        input  wfifo_strobe,
        input  wfifo_data
    );

endinterface

// File: rtl/sf_camera_pixel_packer_byte_to_word.sv
// Packs captured bytes into 32-bit words; presents a completed (or flushed
// partial, zero-padded) word combinationally in the cycle it completes.
module sf_camera_pixel_packer_byte_to_word
    import sf_camera_pixel_packer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_capture,
    input  logic [BYTE_W-1:0] i_byte,
    input  logic              i_flush,
    output logic [DATA_W-1:0] o_word,
    output logic              o_word_vld,
    output logic [1:0]        o_index
);

    logic [1:0]        r_index;
    logic [DATA_W-1:0] r_word;
    logic [1:0]        w_lane;
    logic [DATA_W-1:0] w_word;
    logic              w_vld;

    always_comb begin
        w_lane = BYTE_ORDER_BIG ? (2'd3 - r_index) : r_index;
        w_word = r_word;
        w_vld  = 1'b0;
        if (i_capture) begin
            w_word[{w_lane, 3'b000} +: BYTE_W] = i_byte;
            w_vld = (r_index == 2'd3);
        end else if (i_flush && (r_index != 2'd0)) begin
            w_vld = 1'b1;
        end
    end

    // Unused lanes stay zero because the accumulator clears on every emitted word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_index <= 2'd0;
            r_word  <= '0;
        end else if (w_vld) begin
            r_index <= 2'd0;
            r_word  <= '0;
        end else if (i_capture) begin
            r_index <= r_index + 2'd1;
            r_word  <= w_word;
        end
    end

    assign o_word     = w_word;
    assign o_word_vld = w_vld;
    assign o_index    = r_index;

endmodule

// File: rtl/sf_camera_pixel_packer.sv
// Camera capture stage: frames vsync/hsync-qualified bytes into words, owns
// ping-pong buffer acquisition/release, row/pixel counting and overflow.
module sf_camera_pixel_packer
    import sf_camera_pixel_packer_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_enable,
    input  logic                     i_reset_counts,
    input  logic                     i_vsync,
    input  logic                     i_hsync,
    input  logic [BYTE_W-1:0]        i_pix_data,
    sf_camera_pixel_packer_if.master wfifo,
    output logic [31:0]              o_row_count,
    output logic [31:0]              o_pixel_count,
    output logic                     o_captured,
    output logic                     o_busy,
    output logic                     o_overflow
);

    state_t                 r_state;
    logic                   r_busy;
    logic                   r_vsync_p1;
    logic                   r_hsync_p1;
    logic [1:0]             r_activate;
    logic [FIFO_SIZE_W-1:0] r_size;
    logic [FIFO_SIZE_W-1:0] r_count;
    logic                   r_strobe;
    logic [DATA_W-1:0]      r_data;
    logic [31:0]            r_row_count;
    logic [31:0]            r_pixel_count;
    logic [31:0]            r_row_bytes;
    logic                   r_captured;
    logic                   r_overflow;

    logic                   w_vsync_rise;
    logic                   w_vsync_fall;
    logic                   w_hsync_fall;
    logic                   w_capture;
    logic                   w_row_end;
    logic                   w_flush_req;
    logic                   w_frame_start;
    logic                   w_frame_done;
    logic [DATA_W-1:0]      w_word;
    logic                   w_word_vld;
    logic [1:0]             w_index;
    logic                   w_buf_active;
    logic                   w_write;
    logic                   w_drop;
    logic                   w_full;
    logic                   w_flush_release;

    assign w_vsync_rise  = i_vsync & ~r_vsync_p1;
    assign w_vsync_fall  = ~i_vsync & r_vsync_p1;
    assign w_hsync_fall  = ~i_hsync & r_hsync_p1;
    assign w_capture     = i_vsync & i_hsync & (r_state == ST_FRAME);
    assign w_row_end     = w_hsync_fall & (r_state == ST_FRAME);
    assign w_flush_req   = w_row_end | (r_state == ST_FLUSH);
    assign w_frame_start = (r_state == ST_IDLE) & w_vsync_rise & i_enable;
    // FLUSH lingers until any partial word has left the packer.
    assign w_frame_done  = (r_state == ST_FLUSH) & (w_index == 2'd0);

    assign w_buf_active    = (r_activate != 2'b00);
    assign w_write         = w_word_vld & w_buf_active & (r_count < r_size);
    assign w_drop          = w_word_vld & ~w_buf_active;
    assign w_full          = w_buf_active & (r_count >= r_size);
    assign w_flush_release = w_frame_done & w_buf_active & (r_count != '0);

    sf_camera_pixel_packer_byte_to_word u_b2w (
        .clk        (clk),
        .rst        (rst),
        .i_capture  (w_capture),
        .i_byte     (i_pix_data),
        .i_flush    (w_flush_req),
        .o_word     (w_word),
        .o_word_vld (w_word_vld),
        .o_index    (w_index)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_frame_start) begin
                        r_state <= ST_FRAME;
                        r_busy  <= 1'b1;
                    end
                end
                ST_FRAME: begin
                    if (w_vsync_fall)
                        r_state <= ST_FLUSH;
                end
                ST_FLUSH: begin
                    if (w_frame_done) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync_p1    <= 1'b0;
            r_hsync_p1    <= 1'b0;
            r_row_bytes   <= '0;
            r_row_count   <= '0;
            r_pixel_count <= '0;
            r_captured    <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_vsync_p1 <= i_vsync;
            r_hsync_p1 <= i_hsync;

            if (w_frame_start || w_row_end)
                r_row_bytes <= '0;
            else if (w_capture)
                r_row_bytes <= r_row_bytes + 32'd1;

            if (i_reset_counts || w_frame_start)
                r_row_count <= '0;
            else if (w_row_end)
                r_row_count <= r_row_count + 32'd1;

            if (i_reset_counts)
                r_pixel_count <= '0;
            else if (w_row_end)
                r_pixel_count <= r_row_bytes;

            if (i_reset_counts || w_frame_start)
                r_captured <= 1'b0;
            else if (w_frame_done)
                r_captured <= 1'b1;

            if (i_reset_counts)
                r_overflow <= 1'b0;
            else if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    // A buffer is released the cycle after its last write; re-acquisition waits for 00.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_activate <= 2'b00;
            r_size     <= '0;
            r_count    <= '0;
            r_strobe   <= 1'b0;
            r_data     <= '0;
        end else begin
            r_strobe <= w_write;
            if (w_write) begin
                r_data  <= w_word;
                r_count <= r_count + 24'd1;
            end

            if (!w_buf_active) begin
                if (wfifo.wfifo_ready != 2'b00) begin
                    r_activate <= first_ready(wfifo.wfifo_ready);
                    r_size     <= wfifo.wfifo_size;
                    r_count    <= '0;
                end
            end else if (w_full || w_flush_release) begin
                r_activate <= 2'b00;
            end
        end
    end

    assign wfifo.wfifo_activate = r_activate;
    assign wfifo.wfifo_strobe   = r_strobe;
    assign wfifo.wfifo_data     = r_data;
    assign o_row_count          = r_row_count;
    assign o_pixel_count        = r_pixel_count;
    assign o_captured           = r_captured;
    assign o_busy               = r_busy;
    assign o_overflow           = r_overflow;

endmodule

// File: doc/sf_camera_pixel_packer.md
# sf_camera_pixel_packer

Pixel-clock-domain capture stage that converts the 8-bit camera byte stream, qualified by vsync/hsync, into 32-bit words and writes them into the write side of the camera ping-pong FIFO. The FIFO read side is drained by the Wishbone memory writer. The block owns buffer acquisition and release, row and pixel counting, end-of-frame reporting and overflow detection. It sits between the camera physical pins and the ping-pong FIFO inside `sf_camera`.

## Interface
- No parameters; data width 32, byte width 8, FIFO size width 24 are fixed.
- `clk`  in  1  clock; reset `rst`, synchronous, active-high. The clock is the camera pixel clock.
- `rst`  in  1  synchronous active-high reset.
- `i_enable`  in  1  capture enable; sampled only at frame start.
- `i_reset_counts`  in  1  level; clears the counters and the sticky flags.
- `i_vsync`  in  1  high for the duration of a frame.
- `i_hsync`  in  1  high while the row's bytes are valid.
- `i_pix_data`  in  8  pixel byte.
- `i_wfifo_ready`  in  2  per-buffer ready from the ping-pong FIFO.
- `o_wfifo_activate`  out  2  buffer ownership, one-hot or zero.
- `i_wfifo_size`  in  24  capacity in words of the active buffer.
- `o_wfifo_strobe`  out  1  one-cycle word write.
- `o_wfifo_data`  out  32  word written.
- `o_row_count`  out  32  rows completed in the current frame.
- `o_pixel_count`  out  32  bytes in the last completed row.
- `o_captured`  out  1  sticky flag: a frame has completed.
- `o_busy`  out  1  a frame is in progress.
- `o_overflow`  out  1  sticky flag: a word was dropped because no buffer was active.

## Operation
- **States:**
  - `IDLE`: on vsync rising edge with `i_enable` = 1, go to `FRAME`, clear `o_row_count` and clear `o_captured`. A vsync rising edge with enable = 0 ignores the whole frame; enable rising mid-frame has no effect.
  - `FRAME`: capture bytes. On vsync falling edge, go to `FLUSH`.
  - `FLUSH`: emit any pending partial word, release the buffer, set `o_captured`, then go to `IDLE`.
- **Byte capture:** a byte is captured on every clk where `i_vsync & i_hsync` and the state is `FRAME`.
- **Byte packing:** bytes are packed big-endian. The first byte goes to [31:24] and the fourth to [7:0]. A 2-bit byte index wraps 3→0 on each completed word.
- **Row end (hsync falling edge):**
  - If the byte index is not 0, flush the partial word with the unused low bytes set to zero, and reset the index to 0.
  - Increment `o_row_count`.
  - Load `o_pixel_count` with the row's byte count. The row byte counter is 32-bit and restarts at each row.
- **Buffer acquisition:** when `o_wfifo_activate` = 00, not in reset, and `i_wfifo_ready` ≠ 00, activate bit 0 if it is ready, otherwise bit 1. Latch `i_wfifo_size` and clear the 24-bit word counter.
- **Word write:** a completed word strobes only if a buffer is active and count < size; the counter then increments.
- **Buffer release:** release (activate → 00) when count reaches size, or in `FLUSH` if count > 0. An empty buffer is held across frames.
- **Drop:** a completed word with no active buffer is dropped and `o_overflow` is set. Data is never stalled.
- **`i_reset_counts`:** clears `o_row_count`, `o_pixel_count`, `o_captured` and `o_overflow`. It has no effect on packing or buffer state.
- **`o_busy`:** equals 1 in `FRAME` or `FLUSH`.

## Timing
- **Reset values:**
  - All outputs 0, state `IDLE`, byte index 0.
  - Edge-detect registers for vsync and hsync are 0.
  - Reset asserted mid-frame abandons the partial word and releases the buffer on the following cycle.
- **Latency:** `o_wfifo_strobe`/`o_wfifo_data` assert 1 clk after the 4th byte is sampled, or 1 clk after the hsync falling edge is detected for a partial flush. Data is valid only while strobe is high.
- **Edge detection:** compares the current input with its 1-cycle-delayed copy. Counts update in the same cycle as the strobe.
- **Activation:** asserts 1 clk after ready is seen. Release takes effect 1 clk after the last strobe.
- **Full and word complete in the same cycle:** the word is written as the last word of that buffer, and the buffer is released next cycle. The next buffer is acquired no earlier than the cycle after release. A minimum of 4 byte cycles per word guarantees no loss if the other buffer is ready.
- **vsync fall coinciding with hsync fall:** perform the row flush first, then `FLUSH` on the next cycle.

## Structure
- Shared constants go in `sf_camera_defines.v`: state encodings, byte-order constant and FIFO size width.
- One optional sub-module, `sf_byte_to_word`: the byte index, shift register and partial-flush logic, outputting a word plus a strobe. Everything else stays in the top.

## Test plan
1. Enable = 1, ready = 01, size = 1024; frame of 2 rows × 8 bytes 00..0F → activate = 01, four strobes of 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F. Then row_count = 2, pixel_count = 8, buffer released after vsync fall, captured = 1.
2. One row of 6 bytes 00..05 → strobes 0x00010203 then 0x04050000; pixel_count = 6.
3. Size = 2, ready = 11, one row of 16 bytes → 2 words into buffer 0, release, activate = 10 one clk later, remaining 2 words into buffer 1, no overflow.
4. Ready = 00 for a whole 8-byte row → no strobes, overflow = 1; pulse reset_counts → overflow = 0, row_count = 0.
5. rst high for 1 clk mid-row after 2 bytes → all outputs 0 the next cycle. The following frame packs from byte 0 correctly.
6. Enable = 0 at vsync rise, enable = 1 mid-frame → no activate, no strobes, captured stays 0, busy = 0.
